// File: rtl/sound_seq_pkg.sv
// Shared constants for the sound-effect sequencer: CPU register map, CTRL and
// STATUS bit positions, FSM encoding and the step-entry layout.
package sound_seq_pkg;

  // CPU register addresses
  localparam logic [3:0] ADDR_CTRL   = 4'h0;
  localparam logic [3:0] ADDR_STATUS = 4'h1;
  localparam logic [3:0] ADDR_DATA   = 4'h2;
  localparam logic [3:0] ADDR_STEP   = 4'h3;

  // CTRL write bits
  localparam int CTRL_START = 0;
  localparam int CTRL_STOP  = 1;
  localparam int CTRL_LOOP  = 2;
  localparam int CTRL_CLEAR = 3;

  // STATUS read bits; count occupies bits 3:0
  localparam int STAT_OVF   = 7;
  localparam int STAT_FULL  = 6;
  localparam int STAT_EMPTY = 5;
  localparam int STAT_BUSY  = 4;

  // Step entry {reg[1:0], dur, value[7:0]}; reg sits directly above dur
  localparam int STEP_VAL_LSB = 0;
  localparam int STEP_VAL_W   = 8;
  localparam int STEP_DUR_LSB = 8;
  localparam int STEP_REG_W   = 2;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_ISSUE = 3'd1,
    ST_WAIT  = 3'd2,
    ST_NEXT  = 3'd3,
    ST_MUTE  = 3'd4
  } state_e;

endpackage

// File: rtl/sound_seq_mem.sv
// Step buffer: DEPTH x W register file, synchronous write, asynchronous read.
// Contents are not reset; only entries below the write pointer are ever read.
module sound_seq_mem #(
  parameter int DEPTH = 16,
  parameter int W     = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [W-1:0]  wdata,
  input  logic [AW-1:0] raddr,
  output logic [W-1:0]  rdata
);

  logic [W-1:0] mem_q [DEPTH];

  // Write port: one entry per cycle when we is high
  always_ff @(posedge clk) begin
    if (we) mem_q[waddr] <= wdata;
  end

  assign rdata = mem_q[raddr];

endmodule

// File: rtl/sound_seq_b3.sv
// Sound-effect sequencer on the AVR 8-bit I/O bus. The CPU pushes timed steps
// through DATA/STEP, then START replays them onto the sound block's register
// write port. CPU bus: a write takes effect on the clk edge where we=1; reads
// are combinational while re=1.
// Optional build macro SOUND_SEQ_MUTE_ON_STOP_EN: STOP and non-loop end of
// sequence pass through a MUTE state that writes 0x00 to sound regs 0..3.
module sound_seq_b3
  import sound_seq_pkg::*;
#(
  parameter int DEPTH    = 16,
  parameter int TICK_DIV = 100000,
  parameter int DUR_W    = 6
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [3:0] addr,
  input  logic [7:0] data_in,
  output logic [7:0] data_out,
  input  logic       re,
  input  logic       we,
  output logic [3:0] snd_addr,
  output logic [7:0] snd_data,
  output logic       snd_we,
  output logic       busy
);

  localparam int AW      = $clog2(DEPTH);
  localparam int ENTRY_W = STEP_REG_W + DUR_W + STEP_VAL_W;
  localparam int REG_LSB = STEP_DUR_LSB + DUR_W;
  localparam int TW      = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

  localparam logic [AW:0]      WR_ONE    = (AW+1)'(1);
  localparam logic [AW:0]      FULL_CNT  = (AW+1)'(DEPTH);
  localparam logic [AW-1:0]    RD_ONE    = AW'(1);
  localparam logic [TW-1:0]    TICK_ONE  = TW'(1);
  localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
  localparam logic [DUR_W-1:0] DUR_ONE   = DUR_W'(1);

`ifdef SOUND_SEQ_MUTE_ON_STOP_EN
  localparam state_e END_ST = ST_MUTE;
`else
  localparam state_e END_ST = ST_IDLE;
`endif

  state_e             state_q, state_d;
  logic [AW:0]        wr_ptr_q, wr_ptr_d;
  logic [AW-1:0]      rd_ptr_q, rd_ptr_d;
  logic               loop_q, loop_d;
  logic               ovf_q, ovf_d;
  logic [7:0]         stage_q, stage_d;
  logic [TW-1:0]      tick_q, tick_d;
  logic [DUR_W-1:0]   durc_q, durc_d;
  logic [1:0]         mute_idx_q, mute_idx_d;
  logic [3:0]         hold_addr_q, hold_addr_d;
  logic [7:0]         hold_data_q, hold_data_d;

  logic               push;
  logic [ENTRY_W-1:0] wdata, entry;
  logic [7:0]         cur_val;
  logic [DUR_W-1:0]   cur_dur;
  logic [1:0]         cur_reg;
  logic               ctrl_wr, start, stop, full, empty, last_step;
  logic [3:0]         count_sat;
  logic [7:0]         status;

  sound_seq_mem #(.DEPTH(DEPTH), .W(ENTRY_W)) u_mem (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr_q[AW-1:0]),
    .wdata (wdata),
    .raddr (rd_ptr_q),
    .rdata (entry)
  );

  assign wdata     = {data_in[7:6], data_in[DUR_W-1:0], stage_q};
  assign cur_val   = entry[STEP_VAL_LSB +: STEP_VAL_W];
  assign cur_dur   = entry[STEP_DUR_LSB +: DUR_W];
  assign cur_reg   = entry[REG_LSB +: STEP_REG_W];

  assign busy      = (state_q != ST_IDLE);
  assign ctrl_wr   = we && (addr == ADDR_CTRL);
  assign stop      = ctrl_wr && data_in[CTRL_STOP];
  assign start     = ctrl_wr && data_in[CTRL_START] && !data_in[CTRL_STOP];
  assign full      = (wr_ptr_q == FULL_CNT);
  assign empty     = (wr_ptr_q == '0);
  assign last_step = ({1'b0, rd_ptr_q} == (wr_ptr_q - WR_ONE));
  assign count_sat = (int'(wr_ptr_q) > 15) ? 4'hF : 4'(wr_ptr_q);
  assign status    = {ovf_q, full, empty, busy, count_sat};

  // State and datapath registers
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= ST_IDLE;
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      loop_q      <= 1'b0;
      ovf_q       <= 1'b0;
      stage_q     <= '0;
      tick_q      <= '0;
      durc_q      <= '0;
      mute_idx_q  <= '0;
      hold_addr_q <= '0;
      hold_data_q <= '0;
    end else begin
      state_q     <= state_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      loop_q      <= loop_d;
      ovf_q       <= ovf_d;
      stage_q     <= stage_d;
      tick_q      <= tick_d;
      durc_q      <= durc_d;
      mute_idx_q  <= mute_idx_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
    end
  end

  // CPU register writes: staging, pushes (only while idle) and CLEAR
  always_comb begin
    loop_d   = loop_q;
    ovf_d    = ovf_q;
    stage_d  = stage_q;
    wr_ptr_d = wr_ptr_q;
    push     = 1'b0;
    if (we) begin
      case (addr)
        ADDR_CTRL: begin
          loop_d = data_in[CTRL_LOOP];
          if (data_in[CTRL_CLEAR] && !busy) begin
            wr_ptr_d = '0;
            ovf_d    = 1'b0;
          end
        end
        ADDR_DATA: stage_d = data_in;
        ADDR_STEP: begin
          if (!busy) begin
            if (full) begin
              ovf_d = 1'b1;
            end else begin
              push     = 1'b1;
              wr_ptr_d = wr_ptr_q + WR_ONE;
            end
          end
        end
        default: ;
      endcase
    end
  end

  // Next-state logic; STOP outranks START, both outrank the step walk
  always_comb begin
    state_d    = state_q;
    rd_ptr_d   = rd_ptr_q;
    tick_d     = tick_q;
    durc_d     = durc_q;
    mute_idx_d = mute_idx_q;
    case (state_q)
      ST_IDLE: begin
        if (start && !empty) begin
          rd_ptr_d = '0;
          state_d  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        tick_d  = '0;
        durc_d  = '0;
        state_d = (cur_dur == '0) ? ST_NEXT : ST_WAIT;
      end
      ST_WAIT: begin
        if (tick_q == TICK_LAST) begin
          tick_d = '0;
          if (durc_q == cur_dur - DUR_ONE) state_d = ST_NEXT;
          else                             durc_d  = durc_q + DUR_ONE;
        end else begin
          tick_d = tick_q + TICK_ONE;
        end
      end
      ST_NEXT: begin
        if (last_step) begin
          if (loop_q) begin
            rd_ptr_d = '0;
            state_d  = ST_ISSUE;
          end else begin
            mute_idx_d = '0;
            state_d    = END_ST;
          end
        end else begin
          rd_ptr_d = rd_ptr_q + RD_ONE;
          state_d  = ST_ISSUE;
        end
      end
      ST_MUTE: begin
        mute_idx_d = mute_idx_q + 2'd1;
        if (mute_idx_q == 2'd3) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
    if (busy) begin
      if (stop && state_q != ST_MUTE) begin
        mute_idx_d = '0;
        state_d    = END_ST;
      end else if (start) begin
        rd_ptr_d = '0;
        state_d  = ST_ISSUE;
      end
    end
  end

  // Sound port outputs; address/data hold their last driven value
  always_comb begin
    snd_we      = 1'b0;
    snd_addr    = hold_addr_q;
    snd_data    = hold_data_q;
    case (state_q)
      ST_ISSUE: begin
        snd_we   = 1'b1;
        snd_addr = {2'b00, cur_reg};
        snd_data = cur_val;
      end
      ST_MUTE: begin
        snd_we   = 1'b1;
        snd_addr = {2'b00, mute_idx_q};
        snd_data = 8'h00;
      end
      default: ;
    endcase
    hold_addr_d = snd_addr;
    hold_data_d = snd_data;
  end

  // CPU read mux, zero when not reading or unmapped
  always_comb begin
    data_out = '0;
    if (re) begin
      case (addr)
        ADDR_CTRL:   data_out[CTRL_LOOP] = loop_q;
        ADDR_STATUS: data_out = status;
        default:     data_out = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_sound_seq_b3.sv
// Bench for sound_seq_b3 with TICK_DIV=4. Strobes are checked against an
// expected queue in push order; timing is checked from recorded strobe cycles.
module tb_sound_seq_b3;

  localparam int TICK_DIV = 4;
`ifdef SOUND_SEQ_MUTE_ON_STOP_EN
  localparam int MUTE_N = 4;
`else
  localparam int MUTE_N = 0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [3:0] addr = '0;
  logic [7:0] data_in = '0;
  logic [7:0] data_out;
  logic       re = 1'b0;
  logic       we = 1'b0;
  logic [3:0] snd_addr;
  logic [7:0] snd_data;
  logic       snd_we;
  logic       busy;

  int passes = 0;
  int fails  = 0;
  int cyc    = 0;
  logic [11:0] exp_q[$];
  int          strobe_cyc[$];

  sound_seq_b3 #(.DEPTH(16), .TICK_DIV(TICK_DIV), .DUR_W(6)) dut (
    .clk      (clk),
    .reset    (reset),
    .addr     (addr),
    .data_in  (data_in),
    .data_out (data_out),
    .re       (re),
    .we       (we),
    .snd_addr (snd_addr),
    .snd_data (snd_data),
    .snd_we   (snd_we),
    .busy     (busy)
  );

  // Clock, cycle counter and watchdog
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: every strobe is popped against the expected queue
  always @(negedge clk) begin
    if (snd_we === 1'b1) begin
      logic [11:0] e;
      strobe_cyc.push_back(cyc);
      if (exp_q.size() == 0) begin
        $display("FAIL strobe_unexpected: got addr=%h data=%h, expected none", snd_addr, snd_data);
        fails++;
      end else begin
        e = exp_q.pop_front();
        if ({snd_addr, snd_data} !== e) begin
          $display("FAIL strobe: got addr=%h data=%h, expected addr=%h data=%h",
                   snd_addr, snd_data, e[11:8], e[7:0]);
          fails++;
        end else passes++;
      end
    end
  end

  // Driver tasks; all called just after a rising edge
  task automatic cpu_write(input logic [3:0] a, input logic [7:0] d);
    addr = a; data_in = d; we = 1'b1;
    @(posedge clk); #1;
    we = 1'b0; addr = '0; data_in = '0;
  endtask

  task automatic cpu_read(input logic [3:0] a, output logic [7:0] d);
    addr = a; re = 1'b1;
    #1 d = data_out;
    re = 1'b0; addr = '0;
  endtask

  task automatic push_step(input logic [1:0] r, input logic [7:0] v, input logic [5:0] d);
    cpu_write(4'h2, v);
    cpu_write(4'h3, {r, d});
  endtask

  task automatic push_exp(input logic [1:0] r, input logic [7:0] v);
    exp_q.push_back({2'b00, r, v});
  endtask

  task automatic push_mute_exp();
    for (int i = 0; i < MUTE_N; i++) exp_q.push_back({i[3:0], 8'h00});
  endtask

  task automatic wait_idle(input int budget, output int n);
    n = 0;
    while (busy !== 1'b0 && n < budget) begin
      @(posedge clk); #1;
      n++;
    end
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [7:0] rd;
    reset = 1'b1;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    if ({snd_we, snd_addr, snd_data, busy} !== 14'h0) begin
      $display("FAIL reset_outputs: got we=%b addr=%h data=%h busy=%b, expected all 0", snd_we, snd_addr, snd_data, busy);
      fails++;
    end else passes++;
    addr = 4'h1;
    #1 if (data_out !== 8'h00) begin
      $display("FAIL read_disabled: got %h, expected 00", data_out); fails++;
    end else passes++;
    addr = '0;
    cpu_read(4'h1, rd);
    if (rd !== 8'h20) begin
      $display("FAIL reset_status: got %h, expected 20", rd); fails++;
    end else passes++;
    cpu_read(4'h0, rd);
    if (rd !== 8'h00) begin
      $display("FAIL reset_ctrl: got %h, expected 00", rd); fails++;
    end else passes++;
  endtask

  task automatic test_play_once();
    logic [7:0] rd;
    int base, n, start_cyc;
    push_step(2'd0, 8'hC5, 6'd2);
    push_step(2'd3, 8'h81, 6'd0);
    cpu_read(4'h1, rd);
    if (rd !== 8'h02) begin
      $display("FAIL status_two: got %h, expected 02", rd); fails++;
    end else passes++;
    base = strobe_cyc.size();
    push_exp(2'd0, 8'hC5);
    push_exp(2'd3, 8'h81);
    push_mute_exp();
    cpu_write(4'h0, 8'h01);
    start_cyc = cyc;
    wait_idle(200, n);
    if (busy !== 1'b0 || strobe_cyc.size() - base != 2 + MUTE_N) begin
      $display("FAIL play_once_done: got busy=%b strobes=%0d, expected busy=0 strobes=%0d",
               busy, strobe_cyc.size() - base, 2 + MUTE_N);
      fails++;
    end else begin
      passes++;
      if (strobe_cyc[base] - start_cyc != 0) begin
        $display("FAIL first_latency: got %0d, expected 0", strobe_cyc[base] - start_cyc); fails++;
      end else passes++;
      if (strobe_cyc[base+1] - strobe_cyc[base] != 10) begin
        $display("FAIL issue_spacing: got %0d, expected 10", strobe_cyc[base+1] - strobe_cyc[base]); fails++;
      end else passes++;
      if (cyc - strobe_cyc[base+1] != 2 + MUTE_N) begin
        $display("FAIL busy_fall: got %0d, expected %0d", cyc - strobe_cyc[base+1], 2 + MUTE_N); fails++;
      end else passes++;
    end
    cpu_read(4'h1, rd);
    if (rd !== 8'h02) begin
      $display("FAIL status_after_play: got %h, expected 02", rd); fails++;
    end else passes++;
  endtask

  task automatic test_loop_stop();
    logic [7:0] rd;
    int base, n;
    base = strobe_cyc.size();
    push_exp(2'd0, 8'hC5);
    push_exp(2'd3, 8'h81);
    push_exp(2'd0, 8'hC5);
    cpu_write(4'h0, 8'h05);
    n = 0;
    while (strobe_cyc.size() - base < 3 && n < 100) begin
      @(posedge clk); #1;
      n++;
    end
    if (strobe_cyc.size() - base != 3) begin
      $display("FAIL loop_wrap: got %0d strobes, expected 3", strobe_cyc.size() - base); fails++;
    end else passes++;
    cpu_read(4'h0, rd);
    if (rd !== 8'h04) begin
      $display("FAIL ctrl_loop_read: got %h, expected 04", rd); fails++;
    end else passes++;
    push_step(2'd1, 8'h11, 6'd5);
    cpu_read(4'h1, rd);
    if (rd !== 8'h12) begin
      $display("FAIL push_while_busy: got %h, expected 12", rd); fails++;
    end else passes++;
    push_mute_exp();
    cpu_write(4'h0, 8'h02);
    wait_idle(20, n);
    if (busy !== 1'b0 || n != MUTE_N) begin
      $display("FAIL stop_busy: got busy=%b after %0d cycles, expected busy=0 after %0d", busy, n, MUTE_N); fails++;
    end else passes++;
    idle_cycles(30);
    if (strobe_cyc.size() - base != 3 + MUTE_N) begin
      $display("FAIL stop_no_strobes: got %0d strobes, expected %0d", strobe_cyc.size() - base, 3 + MUTE_N); fails++;
    end else passes++;
    cpu_read(4'h1, rd);
    if (rd !== 8'h02) begin
      $display("FAIL status_after_stop: got %h, expected 02", rd); fails++;
    end else passes++;
  endtask

  task automatic test_start_empty();
    logic [7:0] rd;
    int base;
    cpu_write(4'h0, 8'h08);
    cpu_read(4'h1, rd);
    if (rd !== 8'h20) begin
      $display("FAIL clear_status: got %h, expected 20", rd); fails++;
    end else passes++;
    base = strobe_cyc.size();
    cpu_write(4'h0, 8'h01);
    idle_cycles(10);
    if (busy !== 1'b0 || strobe_cyc.size() != base) begin
      $display("FAIL start_empty: got busy=%b strobes=%0d, expected busy=0 strobes=0", busy, strobe_cyc.size() - base); fails++;
    end else passes++;
  endtask

  task automatic test_overflow();
    logic [7:0] rd;
    logic [7:0] vals[16];
    logic [1:0] regs[16];
    logic [7:0] v;
    logic [1:0] r;
    int base, n;
    for (int i = 0; i < 17; i++) begin
      v = 8'($urandom_range(0, 255));
      r = 2'($urandom_range(0, 3));
      if (i < 16) begin
        vals[i] = v;
        regs[i] = r;
      end
      push_step(r, v, 6'($urandom_range(0, 1)));
    end
    cpu_read(4'h1, rd);
    if (rd !== 8'hCF) begin
      $display("FAIL overflow_status: got %h, expected cf", rd); fails++;
    end else passes++;
    base = strobe_cyc.size();
    for (int i = 0; i < 16; i++) push_exp(regs[i], vals[i]);
    push_mute_exp();
    cpu_write(4'h0, 8'h01);
    wait_idle(400, n);
    if (busy !== 1'b0 || strobe_cyc.size() - base != 16 + MUTE_N) begin
      $display("FAIL full_play: got busy=%b strobes=%0d, expected busy=0 strobes=%0d",
               busy, strobe_cyc.size() - base, 16 + MUTE_N); fails++;
    end else passes++;
    cpu_write(4'h0, 8'h08);
    cpu_read(4'h1, rd);
    if (rd !== 8'h20) begin
      $display("FAIL clear_after_ovf: got %h, expected 20", rd); fails++;
    end else passes++;
  endtask

  task automatic test_start_stop();
    logic [7:0] rd;
    int base;
    push_step(2'd1, 8'h3C, 6'd1);
    base = strobe_cyc.size();
    cpu_write(4'h0, 8'h03);
    if (busy !== 1'b0) begin
      $display("FAIL start_stop_busy: got %b, expected 0", busy); fails++;
    end else passes++;
    idle_cycles(10);
    if (busy !== 1'b0 || strobe_cyc.size() != base) begin
      $display("FAIL start_stop_quiet: got busy=%b strobes=%0d, expected busy=0 strobes=0", busy, strobe_cyc.size() - base); fails++;
    end else passes++;
    cpu_read(4'h1, rd);
    if (rd !== 8'h01) begin
      $display("FAIL start_stop_status: got %h, expected 01", rd); fails++;
    end else passes++;
  endtask

  task automatic test_reset_wait();
    logic [7:0] rd;
    int base;
    cpu_write(4'h0, 8'h08);
    push_step(2'd2, 8'h5A, 6'd3);
    base = strobe_cyc.size();
    push_exp(2'd2, 8'h5A);
    cpu_write(4'h0, 8'h01);
    idle_cycles(3);
    if ({busy, snd_we, snd_addr, snd_data} !== {1'b1, 1'b0, 4'h2, 8'h5A}) begin
      $display("FAIL wait_hold: got busy=%b we=%b addr=%h data=%h, expected busy=1 we=0 addr=2 data=5a",
               busy, snd_we, snd_addr, snd_data); fails++;
    end else passes++;
    reset = 1'b1;
    @(posedge clk); #1;
    if ({snd_we, snd_addr, snd_data, busy} !== 14'h0) begin
      $display("FAIL reset_mid_wait: got we=%b addr=%h data=%h busy=%b, expected all 0", snd_we, snd_addr, snd_data, busy); fails++;
    end else passes++;
    reset = 1'b0;
    cpu_read(4'h1, rd);
    if (rd !== 8'h20) begin
      $display("FAIL reset_mid_status: got %h, expected 20", rd); fails++;
    end else passes++;
    idle_cycles(30);
    if (strobe_cyc.size() - base != 1) begin
      $display("FAIL reset_no_strobes: got %0d strobes, expected 1", strobe_cyc.size() - base); fails++;
    end else passes++;
  endtask

  initial begin
    test_reset();
    test_play_once();
    test_loop_stop();
    test_start_empty();
    test_overflow();
    test_start_stop();
    test_reset_wait();
    if (exp_q.size() != 0) begin
      $display("FAIL scoreboard_drain: got %0d pending, expected 0", exp_q.size()); fails++;
    end else passes++;
    $display("%0d/%0d checks passed", passes, passes + fails);
    $finish;
  end

endmodule
